// File: rtl/sram_controller.sv
// MEM-stage responder: runs one 32-bit load/store as two timed half-word accesses
// on a 16-bit asynchronous SRAM, holding ready low until the access completes.
module sram_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        write_q, write_d;
    logic [16:0] word_q, word_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_d;
    logic [31:0] off;
    logic        last;
    logic        unused_off_bits;

    // Word-aligned only; offsets beyond the SRAM wrap silently.
    assign off             = address - BASE_ADDR;
    assign unused_off_bits = ^{off[31:19], off[1:0]};
    assign last            = (count_q == LAST_COUNT);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        write_d = write_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = read_data;
        case (state_q)
            IDLE: begin
                count_d = 4'd0;
                if (MEM_W_EN) begin
                    write_d = 1'b1;
                    word_d  = off[18:2];
                    wdata_d = write_data;
                    state_d = LO;
                end else if (MEM_R_EN) begin
                    write_d = 1'b0;
                    word_d  = off[18:2];
                    state_d = LO;
                end
            end
            LO: begin
                if (last) begin
                    count_d = 4'd0;
                    state_d = HI;
                    if (!write_q) rdata_d[15:0] = sram_dq_in;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            HI: begin
                if (last) begin
                    count_d = 4'd0;
                    state_d = DONE;
                    if (!write_q) rdata_d[31:16] = sram_dq_in;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            write_q   <= 1'b0;
            word_q    <= 17'd0;
            wdata_q   <= 32'd0;
            read_data <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            write_q   <= write_d;
            word_q    <= word_d;
            wdata_q   <= wdata_d;
            read_data <= rdata_d;
        end
    end

    always_comb begin
        sram_addr   = 18'd0;
        sram_we_n   = 1'b1;
        sram_dq_out = 16'd0;
        sram_dq_oe  = 1'b0;
        if (state_q == LO || state_q == HI) begin
            sram_addr  = {word_q, state_q == HI};
            sram_we_n  = ~write_q;
            sram_dq_oe = write_q;
            if (write_q) sram_dq_out = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
        end
    end

    always_comb begin
        case (state_q)
            IDLE:    ready = ~(MEM_R_EN | MEM_W_EN);
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (5 and 1 wait cycles) on behavioural SRAMs,
// checked every cycle against a transaction-level model plus directed literal checks.
module tb_sram_controller;

    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        r_en, w_en, rdy, we_n, oe;
    logic [1:0][31:0]  addr, wdata, rdata;
    logic [1:0][17:0]  saddr;
    logic [1:0][15:0]  dq_out;
    logic [15:0]       dq_in0, dq_in1;

    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];
    logic        pl_en = 1'b0;
    int          pl_sel = 0;
    logic [17:0] pl_addr = 18'd0;
    logic [15:0] pl_data = 16'd0;

    int tests = 0;
    int fails = 0;
    int we_low0 = 0;
    int oe_cnt0 = 0;

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(5)) dut0 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]), .address(addr[0]),
        .write_data(wdata[0]), .read_data(rdata[0]), .ready(rdy[0]), .sram_addr(saddr[0]),
        .sram_we_n(we_n[0]), .sram_dq_out(dq_out[0]), .sram_dq_oe(oe[0]), .sram_dq_in(dq_in0)
    );

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]), .address(addr[1]),
        .write_data(wdata[1]), .read_data(rdata[1]), .ready(rdy[1]), .sram_addr(saddr[1]),
        .sram_we_n(we_n[1]), .sram_dq_out(dq_out[1]), .sram_dq_oe(oe[1]), .sram_dq_in(dq_in1)
    );

    assign dq_in0 = mem0[saddr[0]];
    assign dq_in1 = mem1[saddr[1]];

    always @(posedge clk) begin
        if (!we_n[0]) mem0[saddr[0]] <= dq_out[0];
        if (!we_n[1]) mem1[saddr[1]] <= dq_out[1];
        if (pl_en) begin
            if (pl_sel == 0) mem0[pl_addr] <= pl_data;
            else             mem1[pl_addr] <= pl_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int wc(input int i);
        return (i == 0) ? 5 : 1;
    endfunction

    function automatic logic [15:0] memrd(input int i, input logic [17:0] a);
        return (i == 0) ? mem0[a] : mem1[a];
    endfunction

    // Model: an accepted request occupies cycles 1..W (low half), W+1..2W (high half)
    // and 2W+1 (done), counted from the cycle it was first seen idle.
    logic        m_busy  [2] = '{1'b0, 1'b0};
    logic        m_write [2] = '{1'b0, 1'b0};
    int          m_k     [2] = '{0, 0};
    logic [16:0] m_word  [2] = '{17'd0, 17'd0};
    logic [31:0] m_wd    [2] = '{32'd0, 32'd0};
    logic [31:0] m_rd    [2] = '{32'd0, 32'd0};

    always @(negedge clk) begin
        logic [31:0] off;
        logic [17:0] e_addr;
        logic [15:0] e_dq;
        logic        e_we_n, e_oe, e_rdy;
        int          k, w;
        if (!we_n[0]) we_low0++;
        if (oe[0]) oe_cnt0++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] = 1'b0;
                m_k[i]    = 0;
                m_rd[i]   = 32'd0;
            end
            w = wc(i);
            k = m_k[i];
            e_addr = 18'd0;
            e_we_n = 1'b1;
            e_oe   = 1'b0;
            e_dq   = 16'd0;
            if (m_busy[i] && k <= 2 * w) begin
                e_addr = {m_word[i], k > w};
                e_we_n = ~m_write[i];
                e_oe   = m_write[i];
                e_dq   = (k > w) ? m_wd[i][31:16] : m_wd[i][15:0];
            end
            e_rdy = m_busy[i] ? (k == 2 * w + 1) : ~(r_en[i] | w_en[i]);
            chk($sformatf("dut%0d ready", i), {31'd0, rdy[i]}, {31'd0, e_rdy});
            chk($sformatf("dut%0d sram_addr", i), {14'd0, saddr[i]}, {14'd0, e_addr});
            chk($sformatf("dut%0d sram_we_n", i), {31'd0, we_n[i]}, {31'd0, e_we_n});
            chk($sformatf("dut%0d sram_dq_oe", i), {31'd0, oe[i]}, {31'd0, e_oe});
            chk($sformatf("dut%0d read_data", i), rdata[i], m_rd[i]);
            if (e_oe) chk($sformatf("dut%0d sram_dq_out", i), {16'd0, dq_out[i]}, {16'd0, e_dq});
            if (!rst) begin
                if (!m_busy[i]) begin
                    if (w_en[i] | r_en[i]) begin
                        off        = addr[i] - BASE;
                        m_busy[i]  = 1'b1;
                        m_k[i]     = 1;
                        m_write[i] = w_en[i];
                        m_word[i]  = off[18:2];
                        if (w_en[i]) m_wd[i] = wdata[i];
                    end
                end else begin
                    if (!m_write[i] && k == w)     m_rd[i][15:0]  = memrd(i, {m_word[i], 1'b0});
                    if (!m_write[i] && k == 2 * w) m_rd[i][31:16] = memrd(i, {m_word[i], 1'b1});
                    if (k == 2 * w + 1) m_busy[i] = 1'b0;
                    else                m_k[i]    = k + 1;
                end
            end
        end
    end

    task automatic preload(input int i, input logic [17:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_sel = i; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Requests are pulsed for one cycle; inputs are scrambled while busy.
    task automatic access(input int i, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int low);
        @(posedge clk); #1;
        r_en[i] = r; w_en[i] = w; addr[i] = a; wdata[i] = d;
        low = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rdy[i]) break;
            low++;
            @(posedge clk); #1;
            r_en[i] = 1'b0; w_en[i] = 1'b0;
            addr[i] = 32'hDEAD_BEE0; wdata[i] = 32'h0BAD_F00D;
        end
    endtask

    initial begin
        int low, we0, oe0;
        rst = 1'b1;
        r_en = '0; w_en = '0; addr = '0; wdata = '0;
        #1;
        chk("reset read_data", rdata[0], 32'd0);
        chk("reset sram_we_n", {31'd0, we_n[0]}, 32'd1);
        chk("reset sram_dq_oe", {31'd0, oe[0]}, 32'd0);
        chk("reset sram_addr", {14'd0, saddr[0]}, 32'd0);
        chk("reset ready", {31'd0, rdy[0]}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        preload(0, 18'd8, 16'hBEEF);
        preload(0, 18'd9, 16'h1234);
        preload(1, 18'h3FE00, 16'h5678);
        preload(1, 18'h3FE01, 16'h9ABC);

        we0 = we_low0;
        access(0, 1'b1, 1'b0, 32'd1040, 32'd0, low);
        chk("read low cycles", low, 32'd11);
        chk("read data", rdata[0], 32'h1234_BEEF);
        chk("read no we", we_low0 - we0, 32'd0);

        we0 = we_low0; oe0 = oe_cnt0;
        access(0, 1'b0, 1'b1, 32'd1024, 32'hCAFE_0001, low);
        chk("write low cycles", low, 32'd11);
        chk("write mem0[0]", {16'd0, mem0[0]}, 32'h0001);
        chk("write mem0[1]", {16'd0, mem0[1]}, 32'hCAFE);
        chk("write we_n low cycles", we_low0 - we0, 32'd10);
        chk("write oe cycles", oe_cnt0 - oe0, 32'd10);
        chk("write keeps read_data", rdata[0], 32'h1234_BEEF);

        access(0, 1'b0, 1'b1, 32'd2000, 32'hA5A5_5A5A, low);
        chk("rt write low cycles", low, 32'd11);
        access(0, 1'b1, 1'b0, 32'd2000, 32'd0, low);
        chk("rt read low cycles", low, 32'd11);
        chk("rt read data", rdata[0], 32'hA5A5_5A5A);
        chk("rt mem0[488]", {16'd0, mem0[488]}, 32'h5A5A);
        chk("rt mem0[489]", {16'd0, mem0[489]}, 32'hA5A5);

        access(0, 1'b1, 1'b1, 32'd1028, 32'h1111_2222, low);
        chk("both low cycles", low, 32'd11);
        chk("both mem0[2]", {16'd0, mem0[2]}, 32'h2222);
        chk("both mem0[3]", {16'd0, mem0[3]}, 32'h1111);
        chk("both keeps read_data", rdata[0], 32'hA5A5_5A5A);

        @(posedge clk); #1;
        r_en[0] = 1'b1; addr[0] = 32'd1040;
        @(posedge clk); #1;
        r_en[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort read_data", rdata[0], 32'd0);
        chk("abort sram_we_n", {31'd0, we_n[0]}, 32'd1);
        chk("abort sram_dq_oe", {31'd0, oe[0]}, 32'd0);
        chk("abort ready", {31'd0, rdy[0]}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        access(0, 1'b1, 1'b0, 32'd1040, 32'd0, low);
        chk("post-abort low cycles", low, 32'd11);
        chk("post-abort read data", rdata[0], 32'h1234_BEEF);

        access(1, 1'b1, 1'b0, 32'd0, 32'd0, low);
        chk("w1 read low cycles", low, 32'd3);
        chk("w1 wrap read data", rdata[1], 32'h9ABC_5678);
        access(1, 1'b0, 1'b1, 32'd1028, 32'h7654_3210, low);
        chk("w1 write low cycles", low, 32'd3);
        chk("w1 mem1[2]", {16'd0, mem1[2]}, 32'h3210);
        chk("w1 mem1[3]", {16'd0, mem1[3]}, 32'h7654);
        access(1, 1'b1, 1'b0, 32'd1028, 32'd0, low);
        chk("w1 readback", rdata[1], 32'h7654_3210);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
